led_frame_ctrl: RTL and testbench

//   Double-buffered frame controller feeding the row-data input of the LED row/column multiplexer.

---
 rtl/led_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_frame_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_ctrl.sv
// rtl/led_frame_ctrl.sv - double-buffered LED frame controller; optional column scroll via LED_FRAME_SCROLL_EN
module led_frame_ctrl #(
   parameter int NUM_ROWS         = 4,
   parameter int NUM_ROWS_WIDTH   = 2,
   parameter int NUM_COLS         = 8,
   parameter int FRAME_HOLD       = 1000,
   parameter int FRAME_HOLD_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         i_rst_n,
   input  logic                         i_wr_valid,
   output logic                         o_wr_ready,
   input  logic [NUM_ROWS_WIDTH-1:0]    i_wr_row,
   input  logic [NUM_COLS-1:0]          i_wr_data,
   input  logic                         i_commit,
`ifdef LED_FRAME_SCROLL_EN
   input  logic                         i_scroll,
`endif
   output logic                         o_commit_done,
   output logic                         o_frame_tick,
   output logic [NUM_ROWS*NUM_COLS-1:0] o_rows_flat
);

   localparam logic [FRAME_HOLD_WIDTH-1:0] HOLD_LAST = FRAME_HOLD_WIDTH'(FRAME_HOLD - 1);
   localparam logic [NUM_ROWS_WIDTH-1:0]   LAST_ROW  = NUM_ROWS_WIDTH'(NUM_ROWS - 1);
   localparam logic [NUM_ROWS_WIDTH:0]     ROW_LIMIT = (NUM_ROWS_WIDTH + 1)'(NUM_ROWS);

   typedef enum logic [1:0] {IDLE, PENDING, SWAP, COPY} state_t;

   state_t                        state;
   logic                          front_sel;
   logic                          back_sel;
   logic [NUM_COLS-1:0]           mem [2][NUM_ROWS];
   logic [NUM_ROWS_WIDTH-1:0]     copy_row;
   logic [FRAME_HOLD_WIDTH-1:0]   frame_cnt;
   logic                          wr_fire;
   logic [NUM_ROWS*NUM_COLS-1:0]  next_flat;

   assign back_sel     = ~front_sel;
   assign wr_fire      = i_wr_valid && o_wr_ready;
   assign o_frame_tick = (frame_cnt == HOLD_LAST);

   // Free-running frame period counter, 0..FRAME_HOLD-1
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         frame_cnt <= '0;
      else if (o_frame_tick)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt + 1'b1;
   end

   // Commit FSM owning both buffers: back-buffer writes, frame-aligned swap, front-to-back copy
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         front_sel     <= 1'b0;
         copy_row      <= '0;
         o_wr_ready    <= 1'b1;
         o_commit_done <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < NUM_ROWS; r++)
               mem[b][r] <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Out-of-range rows complete the handshake but are dropped
               if (wr_fire && ({1'b0, i_wr_row} < ROW_LIMIT))
                  mem[back_sel][i_wr_row] <= i_wr_data;
               if (i_commit) begin
                  state      <= PENDING;
                  o_wr_ready <= 1'b0;
               end
            end
            PENDING: begin
               if (o_frame_tick)
                  state <= SWAP;
            end
            SWAP: begin
               front_sel     <= ~front_sel;
               copy_row      <= '0;
               o_commit_done <= (LAST_ROW == '0);
               state         <= COPY;
            end
            COPY: begin
               // front_sel already points at the new image here
               mem[back_sel][copy_row] <= mem[front_sel][copy_row];
               if (copy_row == LAST_ROW) begin
                  state         <= IDLE;
                  o_wr_ready    <= 1'b1;
                  o_commit_done <= 1'b0;
               end else begin
                  copy_row      <= copy_row + 1'b1;
                  o_commit_done <= (copy_row + 1'b1 == LAST_ROW);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LED_FRAME_SCROLL_EN
   localparam int                OFF_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(NUM_COLS - 1);

   logic [OFF_W-1:0] col_off;
   logic [OFF_W-1:0] col_off_next;

   function automatic logic [NUM_COLS-1:0] rotl(input logic [NUM_COLS-1:0] v,
                                                input logic [OFF_W-1:0]    s);
      logic [2*NUM_COLS-1:0] d;
      d = {v, v} << s;
      return d[2*NUM_COLS-1:NUM_COLS];
   endfunction

   // Scroll offset advances on ticks where scrolling is requested
   always_comb begin
      col_off_next = col_off;
      if (o_frame_tick && i_scroll)
         col_off_next = (col_off == OFF_LAST) ? '0 : col_off + 1'b1;
   end

   // Column offset register, survives swaps
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         col_off <= '0;
      else
         col_off <= col_off_next;
   end
`endif

   // Next displayed image: the incoming front buffer at the swap edge, otherwise the current one
   always_comb begin
      next_flat = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         logic [NUM_COLS-1:0] row_src;
         row_src = (state == SWAP) ? mem[back_sel][r] : mem[front_sel][r];
`ifdef LED_FRAME_SCROLL_EN
         next_flat[r*NUM_COLS +: NUM_COLS] = rotl(row_src, col_off_next);
`else
         next_flat[r*NUM_COLS +: NUM_COLS] = row_src;
`endif
      end
   end

   // Registered row-data output toward the multiplexer
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_rows_flat <= '0;
      else
         o_rows_flat <= next_flat;
   end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// tb/tb_led_frame_ctrl.sv - self-checking bench for led_frame_ctrl
module tb_led_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [1:0]  wr_row;
   logic [7:0]  wr_data;
   logic        commit;
   logic        commit_done;
   logic        frame_tick;
   logic [31:0] rows_flat;
`ifdef LED_FRAME_SCROLL_EN
   logic        scroll;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_frame_ctrl #(
      .NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(8),
      .FRAME_HOLD(10), .FRAME_HOLD_WIDTH(4)
   ) dut (
      .clk(clk),
      .i_rst_n(rst_n),
      .i_wr_valid(wr_valid),
      .o_wr_ready(wr_ready),
      .i_wr_row(wr_row),
      .i_wr_data(wr_data),
      .i_commit(commit),
`ifdef LED_FRAME_SCROLL_EN
      .i_scroll(scroll),
`endif
      .o_commit_done(commit_done),
      .o_frame_tick(frame_tick),
      .o_rows_flat(rows_flat)
   );

   // Reference model: image contents plus scheduled event times
   int cyc;
   bit act;
   int commit_at;
   int s_cyc;
   int back_img [4];
   int front_img [4];
   int off;

   typedef struct {
      logic [1:0]  row;
      logic [7:0]  data;
      logic        do_commit;
      logic [31:0] exp_img;
   } vec_t;
   vec_t vecs [6];

   task automatic model_reset();
      cyc = 0; act = 0; commit_at = -1; s_cyc = -100; off = 0;
      for (int r = 0; r < 4; r++) begin back_img[r] = 0; front_img[r] = 0; end
   endtask

   function automatic int next_tick_after(int k);
      int j;
      j = k + 1;
      while (j % 10 != 9) j++;
      return j;
   endfunction

   function automatic bit exp_ready();
      return !(act && cyc > commit_at);
   endfunction

   function automatic bit exp_tick();
      return (cyc % 10) == 9;
   endfunction

   function automatic bit exp_done();
      return act && (cyc == s_cyc + 4);
   endfunction

   function automatic logic [31:0] exp_rows();
      logic [31:0] res;
      int v, rv;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         v  = front_img[r];
         rv = ((v << off) | (v >> (8 - off))) & 255;
         res[r*8 +: 8] = rv[7:0];
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // One clock cycle: compare outputs, drive inputs, advance the model, move to the next negedge
   task automatic step(input logic v, input logic [1:0] r, input logic [7:0] d,
                       input logic c, input logic sc);
      bit rdy, tk;
      chk("ready", {31'd0, wr_ready}, {31'd0, exp_ready()});
      chk("tick",  {31'd0, frame_tick}, {31'd0, exp_tick()});
      chk("done",  {31'd0, commit_done}, {31'd0, exp_done()});
      chk("rows",  rows_flat, exp_rows());
      wr_valid = v; wr_row = r; wr_data = d; commit = c;
`ifdef LED_FRAME_SCROLL_EN
      scroll = sc;
`endif
      rdy = exp_ready();
      tk  = exp_tick();
      if (rdy && v) back_img[r] = int'(d);
      if (rdy && c) begin
         act = 1; commit_at = cyc; s_cyc = next_tick_after(cyc) + 1;
      end
      if (act && cyc == s_cyc) for (int i = 0; i < 4; i++) front_img[i] = back_img[i];
      if (act && cyc == s_cyc + 4) act = 0;
`ifdef LED_FRAME_SCROLL_EN
      if (tk && sc) off = (off + 1) % 8;
`else
      if (tk && sc) off = off;
`endif
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic finish_commit(input string name);
      int n;
      n = 0;
      while (act && n < 40) begin step(0, 0, 0, 0, 0); n++; end
      if (act) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      int ticks, dones, n;
      vecs[0] = '{2'd0, 8'h0F, 1'b0, 32'h00000000};
      vecs[1] = '{2'd1, 8'hF0, 1'b0, 32'h00000000};
      vecs[2] = '{2'd2, 8'hCC, 1'b0, 32'h00000000};
      vecs[3] = '{2'd3, 8'hAA, 1'b1, 32'hAACCF00F};
      vecs[4] = '{2'd1, 8'hFF, 1'b1, 32'hAACCFF0F};
      vecs[5] = '{2'd0, 8'h00, 1'b1, 32'hAACCFF00};

      rst_n = 1'b0; wr_valid = 0; wr_row = 0; wr_data = 0; commit = 0;
`ifdef LED_FRAME_SCROLL_EN
      scroll = 0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_rows",  rows_flat, 32'h0);
      chk("rst_ready", {31'd0, wr_ready}, 32'd1);
      chk("rst_done",  {31'd0, commit_done}, 32'd0);
      chk("rst_tick",  {31'd0, frame_tick}, 32'd0);
      rst_n = 1'b1;
      model_reset();

      // Write/commit table: staged writes, full commit, incremental edits
      for (int i = 0; i < 6; i++) begin
         step(1, vecs[i].row, vecs[i].data, vecs[i].do_commit, 0);
         if (vecs[i].do_commit) finish_commit("table");
         chk("table_img", rows_flat, vecs[i].exp_img);
      end

      // Lockout: valid held high while busy, repeated commit, write coinciding with commit
      step(1, 3, 8'h55, 1, 0);
      dones = 0; n = 0;
      while (act && n < 40) begin
         if (commit_done) dones++;
         step(1, 2, 8'h99, (n == 1), 0);
         n++;
      end
      chk("lock_done_count", dones, 1);
      chk("lock_img", rows_flat, 32'h55CCFF00);

      // Reset during the last COPY cycle
      step(0, 0, 0, 1, 0);
      n = 0;
      while (cyc < s_cyc + 4 && n < 40) begin step(0, 0, 0, 0, 0); n++; end
      chk("done_before_rst", {31'd0, commit_done}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rows",  rows_flat, 32'h0);
      chk("midrst_done",  {31'd0, commit_done}, 32'd0);
      chk("midrst_ready", {31'd0, wr_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (3) step(0, 0, 0, 0, 0);

`ifdef LED_FRAME_SCROLL_EN
      // Scroll: row 0 = 0x01 rotates left one column per tick
      step(1, 0, 8'h01, 1, 0);
      finish_commit("scroll");
      ticks = 0; n = 0;
      while (ticks < 8 && n < 200) begin
         if (exp_tick()) begin
            step(0, 0, 0, 0, 1);
            ticks++;
            if (ticks == 1) chk("scroll_1", {24'd0, rows_flat[7:0]}, 32'h02);
            if (ticks == 7) chk("scroll_7", {24'd0, rows_flat[7:0]}, 32'h80);
            if (ticks == 8) chk("scroll_8", {24'd0, rows_flat[7:0]}, 32'h01);
         end else begin
            step(0, 0, 0, 0, 1);
         end
         n++;
      end
      if (ticks < 8) chk("scroll_timeout", ticks, 8);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom % 2), 2'($urandom % 4), 8'($urandom),
              1'($urandom % 12 == 0), 1'($urandom % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
